// File: rtl/seg_pkg.sv
// seg_pkg: glyph codes and the glyph-to-cathode decode shared by the scan controller
package seg_pkg;
  localparam logic [3:0] G_0 = 4'h0, G_1 = 4'h1, G_2 = 4'h2, G_3 = 4'h3, G_4 = 4'h4;
  localparam logic [3:0] G_5 = 4'h5, G_6 = 4'h6, G_7 = 4'h7, G_8 = 4'h8, G_9 = 4'h9;
  localparam logic [3:0] G_LB = 4'hA, G_LD = 4'hB, G_UA = 4'hC;
  localparam logic [3:0] G_BLANK = 4'hD, G_DASH = 4'hE, G_E = 4'hF;
  // Active-low cathodes {a,b,c,d,e,f,g}
  function automatic logic [6:0] seg_glyph(input logic [3:0] g);
    case (g)
      G_0:     return 7'b0000001;
      G_1:     return 7'b1001111;
      G_2:     return 7'b0010010;
      G_3:     return 7'b0000110;
      G_4:     return 7'b1001100;
      G_5:     return 7'b0100100;
      G_6:     return 7'b0100000;
      G_7:     return 7'b0001111;
      G_8:     return 7'b0000000;
      G_9:     return 7'b0000100;
      G_LB:    return 7'b1100000;
      G_LD:    return 7'b1000010;
      G_UA:    return 7'b0001000;
      G_DASH:  return 7'b1111110;
      G_E:     return 7'b0110000;
      default: return 7'b1111111;
    endcase
  endfunction
endpackage

// File: rtl/seg_glyph_decode.sv
// seg_glyph_decode: combinational glyph ROM
module seg_glyph_decode
  import seg_pkg::*;
(
  input  logic [3:0] glyph_i,
  output logic [6:0] seg_o
);
  assign seg_o = seg_glyph(glyph_i);
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: N-digit 7-segment scanner with tear-free frame load, anti-ghost blanking, PWM and blink
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int DIGIT_TICKS = 5000,
  parameter int BLANK_TICKS = 64,
  parameter int BRIGHT_W    = 3,
  parameter int BLINK_SCANS = 200
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_valid_i,
  output logic                    load_ready_o,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic [NUM_DIGITS-1:0]   blink_i,
  input  logic [BRIGHT_W-1:0]     bright_i,
  output logic [NUM_DIGITS-1:0]   anode_o,
  output logic [6:0]              seg_o,
  output logic                    dp_n_o,
  output logic                    scan_wrap_o
);
  localparam int TW = $clog2(DIGIT_TICKS);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int SW = $clog2(BLINK_SCANS + 1);
  localparam int SPAN = DIGIT_TICKS - BLANK_TICKS;
  logic [TW-1:0] tick_q, tick_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [SW-1:0] scan_q, scan_d;
  logic phase_q, phase_d;
  logic [4*NUM_DIGITS-1:0] disp_g_q, disp_g_d, pend_g_q, pend_g_d;
  logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d, disp_bl_q, disp_bl_d;
  logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d, pend_bl_q, pend_bl_d;
  logic [BRIGHT_W-1:0] pend_br_q, pend_br_d;
  logic pend_v_q, pend_v_d;
  logic [TW:0] lit_end_q, lit_end_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic [6:0] seg_q, seg_d, dec_seg;
  logic dp_n_q, dp_n_d, wrap_q;
  logic tick_last, wrap, scan_hit, accept, swap, on;
  logic [3:0] cur_g;
  assign cur_g = disp_g_q[{idx_q, 2'b00} +: 4];
  seg_glyph_decode u_dec (.glyph_i(cur_g), .seg_o(dec_seg));
  always_comb begin
    tick_last = tick_q == TW'(DIGIT_TICKS - 1);
    wrap = tick_last && idx_q == IW'(NUM_DIGITS - 1);
    scan_hit = wrap && scan_q == SW'(BLINK_SCANS - 1);
    tick_d = tick_last ? '0 : tick_q + 1'b1;
    idx_d = tick_last ? (wrap ? '0 : idx_q + 1'b1) : idx_q;
    scan_d = wrap ? (scan_hit ? '0 : scan_q + 1'b1) : scan_q;
    phase_d = phase_q ^ scan_hit;
    accept = load_valid_i && !pend_v_q;
    swap = wrap && pend_v_q;
    pend_v_d = accept || (pend_v_q && !swap);
    pend_g_d = accept ? digits_i : pend_g_q;
    pend_dp_d = accept ? dp_i : pend_dp_q;
    pend_bl_d = accept ? blink_i : pend_bl_q;
    pend_br_d = accept ? bright_i : pend_br_q;
    disp_g_d = swap ? pend_g_q : disp_g_q;
    disp_dp_d = swap ? pend_dp_q : disp_dp_q;
    disp_bl_d = swap ? pend_bl_q : disp_bl_q;
    // PWM threshold is only recomputed on frame swap, keeping the multiply off the tick path
    lit_end_d = swap ? (TW+1)'(BLANK_TICKS + ((SPAN * (int'(pend_br_q) + 1)) >> BRIGHT_W)) : lit_end_q;
    on = {1'b0, tick_q} >= (TW+1)'(BLANK_TICKS) && {1'b0, tick_q} < lit_end_q
         && !(disp_bl_q[idx_q] && phase_q);
    anode_d = on ? ~(NUM_DIGITS'(1) << idx_q) : '1;
    seg_d = on ? dec_seg : 7'h7F;
    dp_n_d = on ? ~disp_dp_q[idx_q] : 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q <= '0;
      idx_q <= '0;
      scan_q <= '0;
      phase_q <= 1'b0;
      disp_g_q <= {NUM_DIGITS{G_BLANK}};
      disp_dp_q <= '0;
      disp_bl_q <= '0;
      lit_end_q <= (TW+1)'(DIGIT_TICKS);
      pend_g_q <= '0;
      pend_dp_q <= '0;
      pend_bl_q <= '0;
      pend_br_q <= '0;
      pend_v_q <= 1'b0;
      anode_q <= '1;
      seg_q <= 7'h7F;
      dp_n_q <= 1'b1;
      wrap_q <= 1'b0;
    end else begin
      tick_q <= tick_d;
      idx_q <= idx_d;
      scan_q <= scan_d;
      phase_q <= phase_d;
      disp_g_q <= disp_g_d;
      disp_dp_q <= disp_dp_d;
      disp_bl_q <= disp_bl_d;
      lit_end_q <= lit_end_d;
      pend_g_q <= pend_g_d;
      pend_dp_q <= pend_dp_d;
      pend_bl_q <= pend_bl_d;
      pend_br_q <= pend_br_d;
      pend_v_q <= pend_v_d;
      anode_q <= anode_d;
      seg_q <= seg_d;
      dp_n_q <= dp_n_d;
      wrap_q <= wrap;
    end
  end
  assign load_ready_o = !pend_v_q;
  assign anode_o = anode_q;
  assign seg_o = seg_q;
  assign dp_n_o = dp_n_q;
  assign scan_wrap_o = wrap_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: random frame loads checked against a time-arithmetic model of the scanner
module tb_seg_scan_ctrl;
  localparam int N = 4, DT = 16, BT = 2, BW = 2, BS = 2;
  localparam int SCAN = N * DT;
  logic clk = 0, rst_n = 0, load_valid = 0;
  logic [15:0] digits = 0;
  logic [3:0] dp = 0, blink = 0;
  logic [1:0] bright = 0;
  logic load_ready, dp_n, scan_wrap;
  logic [3:0] anode;
  logic [6:0] seg;
  seg_scan_ctrl #(.NUM_DIGITS(N), .DIGIT_TICKS(DT), .BLANK_TICKS(BT), .BRIGHT_W(BW), .BLINK_SCANS(BS)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid_i(load_valid), .load_ready_o(load_ready),
    .digits_i(digits), .dp_i(dp), .blink_i(blink), .bright_i(bright),
    .anode_o(anode), .seg_o(seg), .dp_n_o(dp_n), .scan_wrap_o(scan_wrap));
  always #5 clk = ~clk;
  int vectors = 0, miscompares = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  // Lit segments of each glyph, by letter
  string segs [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                       "abcdefg", "abcdfg", "cdefg", "bcdeg", "abcefg", "", "g", "adefg"};
  function automatic logic [6:0] glyph7(input int g);
    logic [6:0] r = 7'h7F;
    string s = segs[g];
    for (int k = 0; k < s.len(); k++) r[6 - (int'(s[k]) - 97)] = 1'b0;
    return r;
  endfunction
  int m_c, m_dbr, m_pbr;
  logic [15:0] m_dg, m_pg;
  logic [3:0] m_ddp, m_dbl, m_pdp, m_pbl;
  logic m_pv;
  logic [3:0] e_anode;
  logic [6:0] e_seg;
  logic e_dpn, e_wrap, e_ready;
  task automatic m_reset();
    m_c = 0; m_dg = 16'hDDDD; m_ddp = 0; m_dbl = 0; m_dbr = (1 << BW) - 1; m_pv = 0;
    e_anode = 4'hF; e_seg = 7'h7F; e_dpn = 1; e_wrap = 0; e_ready = 1;
  endtask
  task automatic compare();
    chk("anode", 32'(anode), 32'(e_anode));
    chk("seg", 32'(seg), 32'(e_seg));
    chk("dp_n", 32'(dp_n), 32'(e_dpn));
    chk("scan_wrap", 32'(scan_wrap), 32'(e_wrap));
    chk("load_ready", 32'(load_ready), 32'(e_ready));
  endtask
  task automatic step();
    int tick, idx, phase, lit_end;
    logic on, acc;
    @(posedge clk);
    tick = m_c % DT;
    idx = (m_c / DT) % N;
    phase = (m_c / SCAN / BS) % 2;
    lit_end = BT + ((DT - BT) * (m_dbr + 1)) / (1 << BW);
    on = tick >= BT && tick < lit_end && !(m_dbl[idx] && phase == 1);
    e_anode = on ? ~(4'b1 << idx) : 4'hF;
    e_seg = on ? glyph7(int'(m_dg[idx*4 +: 4])) : 7'h7F;
    e_dpn = on ? !m_ddp[idx] : 1'b1;
    e_wrap = (m_c % SCAN) == SCAN - 1;
    acc = load_valid && !m_pv;
    if (e_wrap && m_pv) begin
      m_dg = m_pg; m_ddp = m_pdp; m_dbl = m_pbl; m_dbr = m_pbr; m_pv = 0;
    end
    if (acc) begin
      m_pg = digits; m_pdp = dp; m_pbl = blink; m_pbr = int'(bright); m_pv = 1;
    end
    e_ready = !m_pv;
    m_c++;
    @(negedge clk);
    compare();
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask
  task automatic offer(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b, input logic [1:0] br);
    load_valid = 1; digits = d; dp = p; blink = b; bright = br;
    step();
    load_valid = 0; digits = $urandom; dp = $urandom; blink = $urandom; bright = $urandom;
  endtask
  task automatic run_rand(input int n, input int vpct);
    for (int i = 0; i < n; i++) begin
      load_valid = $urandom_range(0, 99) < vpct;
      digits = $urandom; dp = $urandom; blink = $urandom; bright = $urandom;
      step();
    end
    load_valid = 0;
  endtask
  initial begin
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    compare();
    rst_n = 1;
    run(3 * SCAN);
    run(20);
    offer(16'h0321, 4'h0, 4'h0, 2'd3);
    run(2 * SCAN);
    while (m_c % SCAN != 5) step();
    offer(16'h5678, 4'h0, 4'h0, 2'd0);
    run(2 * SCAN);
    offer(16'h9ABC, 4'hF, 4'h0, 2'd1);
    run(2 * SCAN);
    offer(16'hEF4D, 4'b0010, 4'b0001, 2'd3);
    run(8 * SCAN);
    // valid held high across two boundaries with data changing every cycle
    run_rand(2 * SCAN + 10, 100);
    run_rand(2000, 25);
    while (m_c % SCAN != 2 * DT + 9) step();
    rst_n = 0;
    #1;
    m_reset();
    compare();
    @(posedge clk);
    @(negedge clk);
    compare();
    rst_n = 1;
    run_rand(3 * SCAN, 20);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
